// File: rtl/ark_lane_engine.sv
// Add-Round-Key: newdata = olddata ^ subkey, LANE_BYTES bytes per clock, LSB lane first.
// Latency: around_finished high the cycle after the NLANES-th edge following an accepted start.
// No backpressure: enable is ignored while busy; ARK_ZEROIZE_EN clears key material after use.
module ark_lane_engine #(
    parameter int BLOCK_W    = 128,
    parameter int LANE_BYTES = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               around_enable,
    input  logic               around_abort,
    input  logic [BLOCK_W-1:0] subkey,
    input  logic [BLOCK_W-1:0] olddata,
    output logic [BLOCK_W-1:0] newdata,
    output logic               around_finished,
    output logic               around_busy
);

    localparam int LW     = 8 * LANE_BYTES;
    localparam int NLANES = BLOCK_W / LW;
    localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLANES - 1);

    if ((BLOCK_W % 8 != 0) || ((BLOCK_W / 8) % LANE_BYTES != 0)) begin : g_param_err
        $error("ark_lane_engine: BLOCK_W must be a multiple of 8 and LANE_BYTES must divide BLOCK_W/8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [BLOCK_W-1:0] data_snap, key_snap, work, work_nxt;
    logic               start, last;
    logic [31:0]        base;

    always_comb begin
        start    = ((state == IDLE) || (state == DONE)) && around_enable && !around_abort;
        last     = (state == RUN) && (cnt == LAST);
        base     = 32'(cnt) * 32'(LW);
        work_nxt = work;
        work_nxt[base +: LW] = data_snap[base +: LW] ^ key_snap[base +: LW];

        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over a concurrent start and over the final-lane completion.
        if (around_abort) state_nxt = IDLE;
    end

    assign around_busy     = (state == RUN);
    assign around_finished = (state == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            data_snap <= '0;
            key_snap  <= '0;
            work      <= '0;
            newdata   <= '0;
        end else begin
            state <= state_nxt;
            if (around_abort) begin
                cnt <= '0;
`ifdef ARK_ZEROIZE_EN
                data_snap <= '0;
                key_snap  <= '0;
                work      <= '0;
                newdata   <= '0;
`endif
            end else if (start) begin
                data_snap <= olddata;
                key_snap  <= subkey;
                work      <= '0;
                cnt       <= '0;
            end else if (state == RUN) begin
                if (last) begin
                    // Final lane goes straight into newdata so the result updates atomically.
                    newdata <= work_nxt;
                    cnt     <= '0;
`ifdef ARK_ZEROIZE_EN
                    data_snap <= '0;
                    key_snap  <= '0;
                    work      <= '0;
`else
                    work      <= work_nxt;
`endif
                end else begin
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ark_lane_engine.sv
// Randomised self-checking bench for ark_lane_engine (default and 4-byte-lane instances).
module tb_ark_lane_engine;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         en, ab, fin, busy;
    logic [127:0] od, sk, nd;
    logic         en4, ab4, fin4, busy4;
    logic [127:0] od4, sk4, nd4;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [127:0] prev;
    logic [127:0] ones;

    always #5 clk = ~clk;

    ark_lane_engine u_dut (
        .clk(clk), .n_rst(n_rst), .around_enable(en), .around_abort(ab),
        .subkey(sk), .olddata(od), .newdata(nd),
        .around_finished(fin), .around_busy(busy)
    );

    ark_lane_engine #(.BLOCK_W(128), .LANE_BYTES(4)) u_dut4 (
        .clk(clk), .n_rst(n_rst), .around_enable(en4), .around_abort(ab4),
        .subkey(sk4), .olddata(od4), .newdata(nd4),
        .around_finished(fin4), .around_busy(busy4)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full operation on the default instance; result is simply d ^ k, 16 cycles later.
    task automatic run_op(input logic [127:0] d, input logic [127:0] k, input bit scramble);
        logic [127:0] exp;
        exp = d ^ k;
        en = 1'b1; od = d; sk = k;
        tick();
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("run_busy", busy, 1);
            chk("run_no_fin", fin, 0);
            chk("run_hold", nd, prev);
            if (scramble) begin
                od = rnd128();
                sk = rnd128();
                en = (i == 5);
            end
            tick();
        end
        en = 1'b0;
        chk("done_fin", fin, 1);
        chk("done_busy", busy, 0);
        chk("done_result", nd, exp);
        prev = exp;
`ifdef ARK_ZEROIZE_EN
        chk("zero_data_snap", u_dut.data_snap, 0);
        chk("zero_key_snap", u_dut.key_snap, 0);
        chk("zero_work", u_dut.work, 0);
`endif
        tick();
        chk("pulse_one_cycle", fin, 0);
        chk("idle_busy", busy, 0);
        chk("idle_hold", nd, prev);
    endtask

    initial begin
        ones = '1;
        n_rst = 1'b0;
        en = 0; ab = 0; od = '0; sk = '0;
        en4 = 0; ab4 = 0; od4 = '0; sk4 = '0;
        prev = '0;
        #3;
        chk("rst_newdata", nd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", fin, 0);
        chk("rst_newdata4", nd4, 0);
        #4 n_rst = 1'b1;
        tick();

        // Known-answer vector
        run_op(128'h3243f6a8885a308d313198a2e0370734,
               128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        chk("kat", nd, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        // Four-byte lanes, back-to-back second operation
        en4 = 1'b1; od4 = ones; sk4 = '0;
        tick();
        en4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l4_busy", busy4, 1);
            chk("l4_no_fin", fin4, 0);
            tick();
        end
        chk("l4_fin", fin4, 1);
        chk("l4_result", nd4, ones);
        en4 = 1'b1; sk4 = ones;
        tick();
        en4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l4b_busy", busy4, 1);
            chk("l4b_no_fin", fin4, 0);
            chk("l4b_hold", nd4, ones);
            tick();
        end
        chk("l4b_fin", fin4, 1);
        chk("l4b_result", nd4, 0);
        tick();
        chk("l4b_pulse", fin4, 0);
        chk("l4b_idle", busy4, 0);

        // Operand scrambling plus ignored enable during RUN
        run_op(rnd128(), rnd128(), 1'b1);

        // Abort at lane 10 with a simultaneous enable
        en = 1'b1; od = rnd128(); sk = rnd128();
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_abort_busy", busy, 1);
        ab = 1'b1; en = 1'b1;
        tick();
        ab = 1'b0; en = 1'b0;
`ifdef ARK_ZEROIZE_EN
        prev = '0;
`endif
        chk("abort_busy", busy, 0);
        chk("abort_fin", fin, 0);
        chk("abort_newdata", nd, prev);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_abort_fin", fin, 0);
            chk("post_abort_busy", busy, 0);
        end

        // Asynchronous reset at lane 7
        run_op(rnd128(), rnd128(), 1'b0);
        en = 1'b1; od = rnd128(); sk = rnd128();
        tick();
        en = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        n_rst = 1'b0;
        #1;
        chk("arst_newdata", nd, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fin", fin, 0);
        #2 n_rst = 1'b1;
        prev = '0;
        tick();
        run_op(rnd128(), rnd128(), 1'b0);

        // Random operations
        for (int n = 0; n < 6; n++) run_op(rnd128(), rnd128(), n[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
